// File: rtl/seq_entry_ctrl.sv
// Hex-entry controller: debounced buttons drive an 8-digit shift register
// with blanking mask, plus a serial compare against a fixed pattern.
module seq_entry_ctrl #(
  parameter int unsigned  DB_LEN  = 3,
  parameter logic [31:0]  PATTERN = 32'h0000_0000
) (
  input  logic        CLK_48,
  input  logic        RST,
  input  logic        CE_1KHZ,
  input  logic [3:0]  BTN,
  input  logic [3:0]  SW,
  output logic [31:0] HEX_OUT,
  output logic [7:0]  BLANK_OUT,
  output logic [3:0]  DIGIT_CNT,
  output logic        FULL,
  output logic        BUSY,
  output logic        RES_VLD,
  output logic        MATCH
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RES
  } state_t;

  localparam logic [3:0] LP_DB_LAST = 4'(DB_LEN - 1);

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_db;
  logic [3:0]  r_db_q;
  logic [3:0]  r_dbc [4];

  state_t      r_state;
  logic [31:0] r_hex;
  logic [7:0]  r_blank;
  logic [3:0]  r_cnt;
  logic        r_full;
  logic        r_busy;
  logic        r_res_vld;
  logic        r_match;
  logic        r_ok;
  logic [2:0]  r_idx;

  logic [3:0]  w_press;
  logic        w_clr;
  logic        w_del;
  logic        w_ent;
  logic        w_chk;
  logic [4:0]  w_base;
  logic        w_nib_ok;

  always_ff @(posedge CLK_48) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 4; i++) r_dbc[i] <= '0;
    end else begin
      r_sync1 <= BTN;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (CE_1KHZ) begin
        for (int i = 0; i < 4; i++) begin
          if (r_sync2[i] != r_db[i]) begin
            if (r_dbc[i] == LP_DB_LAST) begin
              r_db[i]  <= ~r_db[i];
              r_dbc[i] <= '0;
            end else begin
              r_dbc[i] <= r_dbc[i] + 4'd1;
            end
          end else begin
            r_dbc[i] <= '0;
          end
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign w_press = r_db & ~r_db_q;
  assign w_clr   = w_press[2];
  assign w_del   = w_press[1] & ~w_press[2];
  assign w_ent   = w_press[0] & ~|w_press[2:1];
  assign w_chk   = w_press[3] & ~|w_press[2:0];

  assign w_base   = {r_idx, 2'b00};
  assign w_nib_ok = (r_hex[w_base +: 4] == PATTERN[w_base +: 4]);

  always_ff @(posedge CLK_48) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_hex     <= '0;
      r_blank   <= 8'hFF;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
      r_res_vld <= 1'b0;
      r_match   <= 1'b0;
      r_ok      <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_res_vld <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_clr) begin
            r_hex   <= '0;
            r_blank <= 8'hFF;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_match <= 1'b0;
          end else if (w_del) begin
            if (r_cnt != 4'd0) begin
              r_hex   <= {4'h0, r_hex[31:4]};
              r_blank <= {1'b1, r_blank[7:1]};
              r_cnt   <= r_cnt - 4'd1;
              r_full  <= 1'b0;
            end
          end else if (w_ent) begin
            if (!r_full) begin
              r_hex   <= {r_hex[27:0], SW};
              r_blank <= {r_blank[6:0], 1'b0};
              r_cnt   <= r_cnt + 4'd1;
              r_full  <= (r_cnt == 4'd7);
            end
          end else if (w_chk) begin
            r_state <= S_CHECK;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_ok    <= r_full;
          end
        end
        S_CHECK: begin
          r_ok <= r_ok & w_nib_ok;
          if (r_idx == 3'd7) begin
            r_state   <= S_RES;
            r_res_vld <= 1'b1;
            r_match   <= r_ok & w_nib_ok;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_RES: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HEX_OUT   = r_hex;
  assign BLANK_OUT = r_blank;
  assign DIGIT_CNT = r_cnt;
  assign FULL      = r_full;
  assign BUSY      = r_busy;
  assign RES_VLD   = r_res_vld;
  assign MATCH     = r_match;

endmodule

// File: tb/tb_seq_entry_ctrl.sv
// Directed bench for seq_entry_ctrl: vector table for entry/delete/clear,
// hand sequences for check, bounce, busy-time presses and mid-check reset.
module tb_seq_entry_ctrl;

  logic        CLK_48 = 1'b0;
  logic        RST = 1'b1;
  logic        CE_1KHZ = 1'b0;
  logic [3:0]  BTN = '0;
  logic [3:0]  SW = '0;
  logic [31:0] HEX_OUT;
  logic [7:0]  BLANK_OUT;
  logic [3:0]  DIGIT_CNT;
  logic        FULL;
  logic        BUSY;
  logic        RES_VLD;
  logic        MATCH;

  seq_entry_ctrl #(
    .DB_LEN  (3),
    .PATTERN (32'h1234_5678)
  ) dut (
    .CLK_48    (CLK_48),
    .RST       (RST),
    .CE_1KHZ   (CE_1KHZ),
    .BTN       (BTN),
    .SW        (SW),
    .HEX_OUT   (HEX_OUT),
    .BLANK_OUT (BLANK_OUT),
    .DIGIT_CNT (DIGIT_CNT),
    .FULL      (FULL),
    .BUSY      (BUSY),
    .RES_VLD   (RES_VLD),
    .MATCH     (MATCH)
  );

  always #5 CLK_48 = ~CLK_48;

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  sw;
    logic [31:0] hex;
    logic [7:0]  blank;
    logic [3:0]  cnt;
    logic        full;
  } vec_t;

  vec_t tv[22];
  int   n_chk = 0;
  int   n_err = 0;
  int   mon_busy = 0;
  int   mon_vld = 0;
  int   mon_bad = 0;

  always @(negedge CLK_48) begin
    if (BUSY) mon_busy++;
    if (RES_VLD) begin
      mon_vld++;
      if (!BUSY) mon_bad++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_48); #1 CE_1KHZ = 1'b1;
    @(posedge CLK_48); #1 CE_1KHZ = 1'b0;
  endtask

  task automatic tick_lvl(input logic [3:0] b);
    BTN = b;
    repeat (3) @(posedge CLK_48);
    tick();
  endtask

  task automatic press(input logic [3:0] b, input logic [3:0] s);
    SW = s;
    BTN = b;
    repeat (3) @(posedge CLK_48);
    repeat (4) tick();
    BTN = '0;
    repeat (3) @(posedge CLK_48);
    repeat (4) tick();
    @(negedge CLK_48);
  endtask

  task automatic do_check(input string nm, input logic exp_m);
    int b0;
    int v0;
    b0 = mon_busy;
    v0 = mon_vld;
    press(4'h8, 4'h0);
    repeat (6) @(negedge CLK_48);
    chk({nm, "_busy9"}, 32'(mon_busy - b0), 32'd9);
    chk({nm, "_vld1"}, 32'(mon_vld - v0), 32'd1);
    chk({nm, "_match"}, 32'(MATCH), 32'(exp_m));
  endtask

  task automatic enter_seq();
    press(4'h4, 4'h0);
    for (int d = 1; d <= 8; d++) press(4'h1, 4'(d));
  endtask

  initial begin
    tv[0]  = '{4'h1, 4'h1, 32'h0000_0001, 8'hFE, 4'd1, 1'b0};
    tv[1]  = '{4'h1, 4'h2, 32'h0000_0012, 8'hFC, 4'd2, 1'b0};
    tv[2]  = '{4'h1, 4'h3, 32'h0000_0123, 8'hF8, 4'd3, 1'b0};
    tv[3]  = '{4'h1, 4'h4, 32'h0000_1234, 8'hF0, 4'd4, 1'b0};
    tv[4]  = '{4'h1, 4'h5, 32'h0001_2345, 8'hE0, 4'd5, 1'b0};
    tv[5]  = '{4'h1, 4'h6, 32'h0012_3456, 8'hC0, 4'd6, 1'b0};
    tv[6]  = '{4'h1, 4'h7, 32'h0123_4567, 8'h80, 4'd7, 1'b0};
    tv[7]  = '{4'h1, 4'h8, 32'h1234_5678, 8'h00, 4'd8, 1'b1};
    tv[8]  = '{4'h1, 4'h9, 32'h1234_5678, 8'h00, 4'd8, 1'b1};
    tv[9]  = '{4'h4, 4'h0, 32'h0000_0000, 8'hFF, 4'd0, 1'b0};
    tv[10] = '{4'h1, 4'hA, 32'h0000_000A, 8'hFE, 4'd1, 1'b0};
    tv[11] = '{4'h1, 4'hB, 32'h0000_00AB, 8'hFC, 4'd2, 1'b0};
    tv[12] = '{4'h1, 4'hC, 32'h0000_0ABC, 8'hF8, 4'd3, 1'b0};
    tv[13] = '{4'h2, 4'h0, 32'h0000_00AB, 8'hFC, 4'd2, 1'b0};
    tv[14] = '{4'h2, 4'h0, 32'h0000_000A, 8'hFE, 4'd1, 1'b0};
    tv[15] = '{4'h2, 4'h0, 32'h0000_0000, 8'hFF, 4'd0, 1'b0};
    tv[16] = '{4'h2, 4'h0, 32'h0000_0000, 8'hFF, 4'd0, 1'b0};
    tv[17] = '{4'h2, 4'h0, 32'h0000_0000, 8'hFF, 4'd0, 1'b0};
    tv[18] = '{4'h1, 4'h5, 32'h0000_0005, 8'hFE, 4'd1, 1'b0};
    tv[19] = '{4'h5, 4'h6, 32'h0000_0000, 8'hFF, 4'd0, 1'b0};
    tv[20] = '{4'h1, 4'h3, 32'h0000_0003, 8'hFE, 4'd1, 1'b0};
    tv[21] = '{4'h3, 4'h4, 32'h0000_0000, 8'hFF, 4'd0, 1'b0};

    repeat (3) @(posedge CLK_48);
    #1 RST = 1'b0;
    @(negedge CLK_48);
    chk("rst_hex", HEX_OUT, 32'h0);
    chk("rst_blank", 32'(BLANK_OUT), 32'hFF);
    chk("rst_cnt", 32'(DIGIT_CNT), 32'd0);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_vld", 32'(RES_VLD), 32'd0);
    chk("rst_match", 32'(MATCH), 32'd0);

    for (int i = 0; i < 22; i++) begin
      press(tv[i].btn, tv[i].sw);
      chk($sformatf("v%0d_hex", i), HEX_OUT, tv[i].hex);
      chk($sformatf("v%0d_blank", i), 32'(BLANK_OUT), 32'(tv[i].blank));
      chk($sformatf("v%0d_cnt", i), 32'(DIGIT_CNT), 32'(tv[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(FULL), 32'(tv[i].full));
    end

    enter_seq();
    chk("seq_hex", HEX_OUT, 32'h1234_5678);
    do_check("chk_ok", 1'b1);
    press(4'h2, 4'h0);
    press(4'h1, 4'h9);
    chk("seq9_hex", HEX_OUT, 32'h1234_5679);
    do_check("chk_bad", 1'b0);
    press(4'h2, 4'h0);
    press(4'h1, 4'h8);
    do_check("chk_ok2", 1'b1);
    press(4'h2, 4'h0);
    chk("seq7_cnt", 32'(DIGIT_CNT), 32'd7);
    do_check("chk_7dig", 1'b0);
    press(4'h1, 4'h8);
    do_check("chk_ok3", 1'b1);
    press(4'h4, 4'h0);
    chk("clr_match", 32'(MATCH), 32'd0);

    SW = 4'h7;
    tick_lvl(4'h1); tick_lvl(4'h1); tick_lvl(4'h0);
    tick_lvl(4'h1); tick_lvl(4'h1); tick_lvl(4'h1);
    repeat (4) tick_lvl(4'h0);
    @(negedge CLK_48);
    chk("bounce_cnt", 32'(DIGIT_CNT), 32'd1);
    chk("bounce_hex", HEX_OUT, 32'h7);
    tick_lvl(4'h1); tick_lvl(4'h1);
    repeat (4) tick_lvl(4'h0);
    @(negedge CLK_48);
    chk("glitch_cnt", 32'(DIGIT_CNT), 32'd1);

    enter_seq();
    begin
      int b0;
      int v0;
      b0 = mon_busy;
      v0 = mon_vld;
      tick_lvl(4'h8);
      tick_lvl(4'hC);
      tick();
      tick();
      repeat (12) @(negedge CLK_48);
      BTN = '0;
      repeat (3) @(posedge CLK_48);
      repeat (4) tick();
      @(negedge CLK_48);
      chk("bclr_busy9", 32'(mon_busy - b0), 32'd9);
      chk("bclr_vld1", 32'(mon_vld - v0), 32'd1);
      chk("bclr_match", 32'(MATCH), 32'd1);
      chk("bclr_cnt", 32'(DIGIT_CNT), 32'd8);
    end

    begin
      int v0;
      bit seen;
      seen = 1'b0;
      v0 = mon_vld;
      BTN = 4'h8;
      repeat (3) @(posedge CLK_48);
      repeat (3) tick();
      BTN = '0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge CLK_48);
        if (BUSY) seen = 1'b1;
      end
      chk("abort_busy_seen", 32'(seen), 32'd1);
      repeat (3) @(posedge CLK_48);
      #1 RST = 1'b1;
      @(posedge CLK_48);
      #1 RST = 1'b0;
      @(negedge CLK_48);
      chk("abort_hex", HEX_OUT, 32'h0);
      chk("abort_blank", 32'(BLANK_OUT), 32'hFF);
      chk("abort_cnt", 32'(DIGIT_CNT), 32'd0);
      chk("abort_full", 32'(FULL), 32'd0);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_match", 32'(MATCH), 32'd0);
      repeat (20) @(negedge CLK_48);
      chk("abort_novld", 32'(mon_vld - v0), 32'd0);
    end

    chk("vld_in_busy", 32'(mon_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_entry_ctrl.md
# seq_entry_ctrl

Controller for the sequence analyzer's hex-entry datapath. It debounces four raw push-buttons on the 1 kHz clock-enable, then runs the 8-digit hex shift register and its per-digit blanking mask: enter, delete and clear. On request it serially compares the entered sequence against a parameterised pattern. It sits between the board buttons/switches and the 7-segment display driver, and replaces the ad-hoc BTN_OR shift logic.

## Interface

- DB_LEN, 3: consecutive CE_1KHZ samples a button must hold a new level before the debounced state changes (1..15).
- PATTERN, 32'h0000_0000: reference sequence; nibble 7 is the first digit entered, nibble 0 the last.
- CLK_48  in  1  system clock, 48 MHz.
- RST  in  1  synchronous, active-high reset.
- CE_1KHZ  in  1  one-cycle clock-enable at 1 kHz, from the divider.
- BTN  in  4  raw buttons, active high: [0] enter, [1] delete, [2] clear, [3] check.
- SW  in  4  hex digit to enter.
- HEX_OUT  out  32  digit register; nibble 0 is the most recent digit.
- BLANK_OUT  out  8  per-digit blank, 1 = digit off.
- DIGIT_CNT  out  4  number of entered digits, 0..8.
- FULL  out  1  DIGIT_CNT == 8.
- BUSY  out  1  check in progress (CHECK or RES state).
- RES_VLD  out  1  one-cycle pulse when MATCH is updated.
- MATCH  out  1  result of the last check.

## Operation

- Reset values: HEX_OUT = 0, BLANK_OUT = 8'hFF, DIGIT_CNT = 0, FULL = 0, BUSY = 0, RES_VLD = 0, MATCH = 0. Synchronisers, debounced states, debounce counters and the FSM are all cleared.
- Input path:
  - Each BTN bit passes through a 2-FF synchroniser.
  - On each CE_1KHZ cycle, the debounce counter for a bit increments if the synchronised level differs from that bit's debounced state; otherwise the counter clears.
  - When the counter reaches DB_LEN, the debounced state toggles and the counter clears.
  - A debounced 0→1 transition produces a one-cycle press pulse. Releases produce no pulse.
- Command priority when press pulses coincide in one cycle: clear > delete > enter > check. Only the highest-priority pulse acts; the others are dropped.
- FSM states: IDLE, CHECK, RES.
- In IDLE:
  - clear: HEX_OUT = 0, BLANK_OUT = 8'hFF, DIGIT_CNT = 0, MATCH = 0.
  - enter with DIGIT_CNT < 8: HEX_OUT = {HEX_OUT[27:0], SW}, BLANK_OUT = {BLANK_OUT[6:0], 1'b0}, DIGIT_CNT + 1. Enter while FULL is ignored.
  - delete with DIGIT_CNT > 0: HEX_OUT = {4'h0, HEX_OUT[31:4]}, BLANK_OUT = {1'b1, BLANK_OUT[7:1]}, DIGIT_CNT − 1. Delete while empty is ignored.
  - check: go to CHECK with index = 0 and the internal flag ok = (DIGIT_CNT == 8).
- In CHECK (8 cycles, index 0..7):
  - Each cycle, ok &= (HEX_OUT[4·index +: 4] == PATTERN[4·index +: 4]).
  - After index 7, go to RES.
- In RES (1 cycle): MATCH = ok, RES_VLD = 1, then return to IDLE.
- In CHECK and RES, every press pulse is dropped, including clear. Debouncing continues.
- Invariant: BLANK_OUT always has exactly DIGIT_CNT low bits, contiguous from bit 0.
- MATCH holds its value until the next RES or a clear.
- RST asserted in any state, including mid-check, returns all outputs to reset values on the next edge. No RES_VLD is produced for an aborted check.

## Timing

- Synchroniser: 2 CLK_48 cycles.
- Debounce: a press is accepted on the DB_LEN-th consecutive CE_1KHZ tick carrying the new level, i.e. (DB_LEN−1)..DB_LEN ms after the level reaches the synchroniser output.
- Press pulse: asserted in the cycle after the debounced state rises.
- Datapath registers update on the clock edge that ends the pulse cycle.
- Check: BUSY rises the cycle after the check pulse. CHECK lasts 8 cycles, RES 1 cycle, so BUSY is high for 9 cycles. RES_VLD is coincident with the last BUSY cycle. MATCH is valid from that cycle on.
- A glitch shorter than DB_LEN CE ticks never changes the debounced state.

## Test plan

- Reset, then enter 1,2,…,8 via SW plus enter presses → HEX_OUT = 32'h1234_5678, BLANK_OUT = 8'h00, DIGIT_CNT = 8, FULL = 1. A 9th enter with SW = 9 → no change.
- After 3 entered digits (A,B,C), delete → HEX_OUT = 32'h0000_00AB, BLANK_OUT = 8'hFC, DIGIT_CNT = 2. Four more deletes → empty, BLANK_OUT = 8'hFF, count stays 0.
- PATTERN = 32'h1234_5678, enter that sequence, then check → BUSY high for exactly 9 cycles, RES_VLD pulse, MATCH = 1. Change the last digit to 9 and re-check → MATCH = 0. Check with 7 digits → MATCH = 0.
- Raw BTN[0] bounces high for 2 CE ticks, low 1, high 3 with DB_LEN = 3 → exactly one enter executes. A 2-tick-only pulse → no enter.
- Enter and clear pulses in the same cycle → clear wins, DIGIT_CNT = 0. A clear press during CHECK → ignored, check completes normally.
- RST asserted on the 4th CHECK cycle → next cycle all outputs at reset values, no RES_VLD.
